// File: rtl/xm_axis_pkt_gen.sv
// xm_axis_pkt_gen: per-lane AXIS frame source for MAC transmit bring-up.
// Emits frame_num frames of frame_len bytes (byte k = seed + k), paced by an
// inter-frame gap and throttled by the number of frames awaiting a response.
// Ports:
//   clk_i, rst_n_i              lane tx_user_clk, async active-low reset
//   start_i, stop_i             run control pulses
//   frame_len_i, frame_num_i,
//   gap_i, seed_i, err_inject_i run configuration (captured on start)
//   tx_data_o/vldb_o/valid_o/
//   ready_i/last_o/user_o       AXIS transmit beat
//   tx_rsp_valid_i, tx_status_i per-frame response (1 = OK)
//   busy_o, done_o, spurious_o  status
//   sent_cnt_o, ok_cnt_o,
//   err_cnt_o                   wrapping 32-bit counters
module xm_axis_pkt_gen #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic [31:0]      frame_num_i,
  input  logic [7:0]       gap_i,
  input  logic [7:0]       seed_i,
  input  logic             err_inject_i,
  output logic [31:0]      tx_data_o,
  output logic [1:0]       tx_vldb_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             tx_last_o,
  output logic             tx_user_o,
  input  logic             tx_rsp_valid_i,
  input  logic             tx_status_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             spurious_o,
  output logic [31:0]      sent_cnt_o,
  output logic [31:0]      ok_cnt_o,
  output logic [31:0]      err_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  logic [31:0]      num_q, num_d, sent_q, sent_d, ok_q, ok_d, err_q, err_d;
  logic [7:0]       gap_q, gap_d, gcnt_q, gcnt_d, seed_q, seed_d, off_q, off_d;
  logic [3:0]       out_q, out_d;
  logic             stop_q, stop_d, user_q, user_d, spur_q, spur_d;

  logic        in_send, is_last, hs, last_hs, rsp, spur_now, rsp_cnt;
  logic        stop_pend, credit, run_done;
  logic [3:0]  out_nxt;
  logic [31:0] sent_inc;

  assign in_send   = (state_q == S_SEND);
  assign is_last   = (rem_q <= LEN_W'(4));
  assign hs        = in_send && tx_ready_i;
  assign last_hs   = hs && is_last;
  assign rsp       = tx_rsp_valid_i && (state_q != S_IDLE);
  // A response with nothing outstanding is only legal if a frame closes in
  // the same cycle; otherwise it is flagged and not counted.
  assign spur_now  = rsp && (out_q == 4'd0) && !last_hs;
  assign rsp_cnt   = rsp && !spur_now;
  assign stop_pend = stop_q || stop_i;
  assign sent_inc  = sent_q + 32'd1;
  assign run_done  = (num_q != 32'd0) && (sent_inc == num_q);

  always_comb begin
    out_nxt = out_q;
    if (last_hs && !rsp_cnt)      out_nxt = out_q + 4'd1;
    else if (!last_hs && rsp_cnt) out_nxt = out_q - 4'd1;
  end

  // Credit is judged on the count as it will stand next cycle.
  assign credit = (out_nxt < MAX_O);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    num_d   = num_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    seed_d  = seed_q;
    off_d   = off_q;
    stop_d  = stop_q || stop_i;
    user_d  = user_q;
    spur_d  = spur_q || spur_now;
    out_d   = out_nxt;
    sent_d  = last_hs ? sent_inc : sent_q;
    ok_d    = (rsp_cnt && tx_status_i)  ? ok_q + 32'd1  : ok_q;
    err_d   = (rsp_cnt && !tx_status_i) ? err_q + 32'd1 : err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          len_d   = (frame_len_i == '0) ? LEN_W'(1) : frame_len_i;
          num_d   = frame_num_i;
          gap_d   = gap_i;
          seed_d  = seed_i;
          sent_d  = '0;
          ok_d    = '0;
          err_d   = '0;
          out_d   = '0;
          spur_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d   = len_q;
        off_d   = '0;
        user_d  = err_inject_i;
        stop_d  = 1'b0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs && !is_last) begin
          rem_d = rem_q - LEN_W'(4);
          off_d = off_q + 8'd4;
        end else if (last_hs) begin
          if (run_done || stop_pend) begin
            state_d = S_WAIT;
          end else if (gap_q != 8'd0) begin
            gcnt_d  = gap_q;
            state_d = S_GAP;
          end else if (credit) begin
            rem_d  = len_q;
            off_d  = '0;
            user_d = err_inject_i;
          end else begin
            // zero-length gap doubles as a wait for response credit
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (stop_pend) begin
          state_d = S_WAIT;
        end else if (gcnt_q <= 8'd1 && credit) begin
          rem_d   = len_q;
          off_d   = '0;
          user_d  = err_inject_i;
          state_d = S_SEND;
        end else if (gcnt_q != 8'd0) begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (out_q == 4'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      seed_q  <= '0;
      off_q   <= '0;
      out_q   <= '0;
      stop_q  <= 1'b0;
      user_q  <= 1'b0;
      spur_q  <= 1'b0;
      sent_q  <= '0;
      ok_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      seed_q  <= seed_d;
      off_q   <= off_d;
      out_q   <= out_d;
      stop_q  <= stop_d;
      user_q  <= user_d;
      spur_q  <= spur_d;
      sent_q  <= sent_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Byte lanes: only bytes still inside the frame carry pattern, the rest are 0.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign tx_data_o[8*b +: 8] = (in_send && (LEN_W'(b) < rem_q)) ?
                                 (seed_q + off_q + 8'(b)) : 8'd0;
  end

  assign tx_vldb_o  = !in_send ? 2'd0 : (is_last ? 2'(rem_q - LEN_W'(1)) : 2'd3);
  assign tx_valid_o = in_send;
  assign tx_last_o  = in_send && is_last;
  assign tx_user_o  = in_send && is_last && user_q;
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign spurious_o = spur_q;
  assign sent_cnt_o = sent_q;
  assign ok_cnt_o   = ok_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_xm_axis_pkt_gen.sv
// tb_xm_axis_pkt_gen: self-checking bench for xm_axis_pkt_gen (MAX_OUTSTANDING=2).
// Frames are checked against a byte-pattern model; responses come from an
// automatic responder or from explicit requests made by the scenario tasks.
module tb_xm_axis_pkt_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i, start_i, stop_i, err_inject_i, tx_ready_i;
  logic        tx_rsp_valid_i, tx_status_i;
  logic [15:0] frame_len_i;
  logic [31:0] frame_num_i;
  logic [7:0]  gap_i, seed_i;
  logic [31:0] tx_data_o, sent_cnt_o, ok_cnt_o, err_cnt_o;
  logic [1:0]  tx_vldb_o;
  logic        tx_valid_o, tx_last_o, tx_user_o, busy_o, done_o, spurious_o;

  xm_axis_pkt_gen #(.MAX_OUTSTANDING(2), .LEN_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
    .frame_len_i(frame_len_i), .frame_num_i(frame_num_i), .gap_i(gap_i),
    .seed_i(seed_i), .err_inject_i(err_inject_i), .tx_data_o(tx_data_o),
    .tx_vldb_o(tx_vldb_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_last_o(tx_last_o), .tx_user_o(tx_user_o),
    .tx_rsp_valid_i(tx_rsp_valid_i), .tx_status_i(tx_status_i),
    .busy_o(busy_o), .done_o(done_o), .spurious_o(spurious_o),
    .sent_cnt_o(sent_cnt_o), .ok_cnt_o(ok_cnt_o), .err_cnt_o(err_cnt_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  v;
    logic        l;
    logic        u;
    int          c;
  } beat_t;

  beat_t beats[$];
  int    cyc = 0;          // negedge count, owned by monitor
  int    lasts_seen = 0;   // owned by monitor
  int    stall_err = 0;    // owned by monitor
  int    rsp_issued = 0;   // owned by responder
  int    man_done = 0;     // owned by responder
  int    exp_ok = 0, exp_err = 0;
  int    man_req = 0;
  bit    man_status = 1'b1;
  bit    auto_en = 1'b1, auto_ok_only = 1'b0;
  int    n_checks = 0, n_pass = 0;

  // Monitor: records handshaked beats and checks hold-while-stalled.
  initial begin
    logic        pv, pr, pl, pu;
    logic [31:0] pd;
    logic [1:0]  pvb;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pu = 1'b0; pd = '0; pvb = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_n_i === 1'b1) begin
        if (pv && !pr && (tx_valid_o !== 1'b1 || tx_data_o !== pd ||
            tx_vldb_o !== pvb || tx_last_o !== pl || tx_user_o !== pu))
          stall_err++;
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
          beats.push_back('{d: tx_data_o, v: tx_vldb_o, l: tx_last_o, u: tx_user_o, c: cyc});
          if (tx_last_o === 1'b1) lasts_seen++;
        end
        pv = tx_valid_o; pr = tx_ready_i; pd = tx_data_o;
        pvb = tx_vldb_o; pl = tx_last_o; pu = tx_user_o;
      end else begin
        pv = 1'b0;
      end
    end
  end

  // Responder: explicit requests first, else one response per closed frame.
  initial begin
    tx_rsp_valid_i = 1'b0;
    tx_status_i    = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (man_req != man_done) begin
        tx_rsp_valid_i = 1'b1;
        tx_status_i    = man_status;
        man_done++;
        rsp_issued++;
        if (man_status) exp_ok++; else exp_err++;
      end else if (auto_en && lasts_seen > rsp_issued) begin
        tx_rsp_valid_i = 1'b1;
        tx_status_i    = auto_ok_only ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_issued++;
        if (tx_status_i) exp_ok++; else exp_err++;
      end else begin
        tx_rsp_valid_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_run(input int len, input int num, input int gap, input int seed,
                           output int b0, output int c_set);
    tick();
    frame_len_i = 16'(len);
    frame_num_i = 32'(num);
    gap_i       = 8'(gap);
    seed_i      = 8'(seed);
    start_i     = 1'b1;
    b0          = beats.size();
    c_set       = cyc;
    tick();
    start_i = 1'b0;
  endtask

  // Reference model: byte k of a frame is (seed+k) mod 256, packed LSB first.
  function automatic int payload_errs(input int b0, input int len, input int seed,
                                      input int frames, input bit eu);
    int le, nbpf, errs, i, rem;
    logic [31:0] w;
    le = (len == 0) ? 1 : len;
    nbpf = (le + 3) / 4;
    errs = 0;
    for (int f = 0; f < frames; f++) begin
      for (int b = 0; b < nbpf; b++) begin
        i = b0 + f * nbpf + b;
        if (i >= beats.size()) begin
          errs++;
          continue;
        end
        w = '0;
        for (int k = 0; k < 4; k++)
          if (4 * b + k < le) w[8*k +: 8] = 8'((seed + 4 * b + k) % 256);
        rem = le - 4 * b;
        if (beats[i].d !== w) errs++;
        if (beats[i].v !== 2'((rem > 4) ? 3 : rem - 1)) errs++;
        if (beats[i].l !== (b == nbpf - 1)) errs++;
        if (beats[i].u !== ((b == nbpf - 1) && eu)) errs++;
      end
    end
    if (beats.size() != b0 + frames * nbpf) errs++;
    return errs;
  endfunction

  task automatic test_reset();
    rst_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; err_inject_i = 1'b0;
    tx_ready_i = 1'b1; frame_len_i = '0; frame_num_i = '0; gap_i = '0; seed_i = '0;
    repeat (3) @(negedge clk_i);
    n_checks++; if (tx_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid_o); else n_pass++;
    n_checks++; if (tx_data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", tx_data_o); else n_pass++;
    n_checks++; if (tx_vldb_o !== 2'd0) $display("FAIL reset_vldb: got %0d want 0", tx_vldb_o); else n_pass++;
    n_checks++; if ({busy_o, done_o, spurious_o, tx_last_o, tx_user_o} !== 5'd0)
      $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, spurious_o, tx_last_o, tx_user_o}); else n_pass++;
    n_checks++; if ({sent_cnt_o, ok_cnt_o, err_cnt_o} !== 96'd0)
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0", sent_cnt_o, ok_cnt_o, err_cnt_o); else n_pass++;
    tick();
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_frame_shape();
    int b0, cs;
    bit ok;
    auto_en = 1'b1; auto_ok_only = 1'b1; tx_ready_i = 1'b1;
    start_run(6, 1, 0, 'h10, b0, cs);
    wait_done(100, ok);
    n_checks++; if (!ok) $display("FAIL shape_done: got timeout want done"); else n_pass++;
    n_checks++; if (beats.size() - b0 != 2) $display("FAIL shape_beats: got %0d want 2", beats.size() - b0); else n_pass++;
    if (beats.size() - b0 >= 2) begin
      n_checks++; if (beats[b0].d !== 32'h13121110 || beats[b0].v !== 2'd3 || beats[b0].l !== 1'b0)
        $display("FAIL shape_beat0: got %h/%0d/%b want 13121110/3/0", beats[b0].d, beats[b0].v, beats[b0].l); else n_pass++;
      n_checks++; if (beats[b0+1].d !== 32'h00001514 || beats[b0+1].v !== 2'd1 || beats[b0+1].l !== 1'b1)
        $display("FAIL shape_beat1: got %h/%0d/%b want 00001514/1/1", beats[b0+1].d, beats[b0+1].v, beats[b0+1].l); else n_pass++;
      n_checks++; if (beats[b0].c != cs + 3) $display("FAIL shape_latency: got %0d want %0d", beats[b0].c, cs + 3); else n_pass++;
    end
    n_checks++; if (ok_cnt_o !== 32'd1) $display("FAIL shape_ok: got %0d want 1", ok_cnt_o); else n_pass++;
    n_checks++; if (sent_cnt_o !== 32'd1) $display("FAIL shape_sent: got %0d want 1", sent_cnt_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL shape_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_throughput(input int gap);
    int b0, cs, ok0, err0, seed;
    bit ok;
    auto_en = 1'b1; auto_ok_only = 1'b0; tx_ready_i = 1'b1;
    seed = $urandom_range(0, 255);
    ok0 = exp_ok; err0 = exp_err;
    start_run(8, 3, gap, seed, b0, cs);
    wait_done(200, ok);
    n_checks++; if (!ok) $display("FAIL tput%0d_done: got timeout want done", gap); else n_pass++;
    n_checks++; if (payload_errs(b0, 8, seed, 3, 1'b0) != 0)
      $display("FAIL tput%0d_payload: got %0d bad want 0", gap, payload_errs(b0, 8, seed, 3, 1'b0)); else n_pass++;
    if (beats.size() - b0 == 6) begin
      n_checks++; if (beats[b0+2].c - beats[b0+1].c != gap + 1 || beats[b0+4].c - beats[b0+3].c != gap + 1)
        $display("FAIL tput%0d_spacing: got %0d,%0d want %0d", gap, beats[b0+2].c - beats[b0+1].c,
                 beats[b0+4].c - beats[b0+3].c, gap + 1); else n_pass++;
      n_checks++; if (beats[b0+5].c - beats[b0].c != 5 + 2 * gap)
        $display("FAIL tput%0d_span: got %0d want %0d", gap, beats[b0+5].c - beats[b0].c, 5 + 2 * gap); else n_pass++;
    end
    n_checks++; if (sent_cnt_o !== 32'd3) $display("FAIL tput%0d_sent: got %0d want 3", gap, sent_cnt_o); else n_pass++;
    n_checks++; if (ok_cnt_o !== 32'(exp_ok - ok0) || err_cnt_o !== 32'(exp_err - err0))
      $display("FAIL tput%0d_rsp: got %0d/%0d want %0d/%0d", gap, ok_cnt_o, err_cnt_o, exp_ok - ok0, exp_err - err0); else n_pass++;
  endtask

  task automatic test_backpressure(input int iter);
    int b0, cs, len, seed, gap, ok0, err0, s0;
    bit ok, eu;
    auto_en = 1'b1; auto_ok_only = 1'b0;
    len = $urandom_range(1, 40); seed = $urandom_range(0, 255); gap = $urandom_range(0, 3);
    eu = 1'($urandom_range(0, 1));
    err_inject_i = eu;
    ok0 = exp_ok; err0 = exp_err; s0 = stall_err;
    start_run(len, 3, gap, seed, b0, cs);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      tx_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (done_o === 1'b1) ok = 1'b1;
    end
    tx_ready_i = 1'b1;
    err_inject_i = 1'b0;
    n_checks++; if (!ok) $display("FAIL bp%0d_done: got timeout want done", iter); else n_pass++;
    n_checks++; if (stall_err != s0) $display("FAIL bp%0d_hold: got %0d changes want 0", iter, stall_err - s0); else n_pass++;
    n_checks++; if (payload_errs(b0, len, seed, 3, eu) != 0)
      $display("FAIL bp%0d_payload len=%0d: got %0d bad want 0", iter, len, payload_errs(b0, len, seed, 3, eu)); else n_pass++;
    n_checks++; if (ok_cnt_o !== 32'(exp_ok - ok0) || err_cnt_o !== 32'(exp_err - err0) || sent_cnt_o !== 32'd3)
      $display("FAIL bp%0d_counts: got %0d/%0d/%0d want 3/%0d/%0d", iter, sent_cnt_o, ok_cnt_o, err_cnt_o,
               exp_ok - ok0, exp_err - err0); else n_pass++;
  endtask

  task automatic test_credit();
    int b0, cs, seed;
    bit ok;
    auto_en = 1'b0; tx_ready_i = 1'b1;
    seed = $urandom_range(0, 255);
    start_run(4, 5, 0, seed, b0, cs);
    repeat (20) @(negedge clk_i);
    n_checks++; if (beats.size() - b0 != 2 || sent_cnt_o !== 32'd2)
      $display("FAIL credit_stall: got %0d beats sent %0d want 2", beats.size() - b0, sent_cnt_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1 || tx_valid_o !== 1'b0)
      $display("FAIL credit_busy: got busy %b valid %b want 1 0", busy_o, tx_valid_o); else n_pass++;
    tick(); man_status = 1'b0; man_req++;
    repeat (10) @(negedge clk_i);
    n_checks++; if (sent_cnt_o !== 32'd3 || err_cnt_o !== 32'd1)
      $display("FAIL credit_after_err: got sent %0d err %0d want 3 1", sent_cnt_o, err_cnt_o); else n_pass++;
    tick(); man_status = 1'b1; man_req++;
    repeat (10) @(negedge clk_i);
    n_checks++; if (sent_cnt_o !== 32'd4 || ok_cnt_o !== 32'd1)
      $display("FAIL credit_after_ok: got sent %0d ok %0d want 4 1", sent_cnt_o, ok_cnt_o); else n_pass++;
    auto_ok_only = 1'b1; auto_en = 1'b1;
    wait_done(200, ok);
    n_checks++; if (!ok) $display("FAIL credit_done: got timeout want done"); else n_pass++;
    n_checks++; if (sent_cnt_o !== 32'd5 || err_cnt_o !== 32'd1 || ok_cnt_o !== 32'd4)
      $display("FAIL credit_counts: got %0d/%0d/%0d want 5/4/1", sent_cnt_o, ok_cnt_o, err_cnt_o); else n_pass++;
    n_checks++; if (payload_errs(b0, 4, seed, 5, 1'b0) != 0)
      $display("FAIL credit_payload: got %0d bad want 0", payload_errs(b0, 4, seed, 5, 1'b0)); else n_pass++;
  endtask

  task automatic test_stop_errinj();
    int b0, cs, seed, s_cyc, started, nb;
    bit ok;
    auto_en = 1'b1; auto_ok_only = 1'b1; tx_ready_i = 1'b1; err_inject_i = 1'b1;
    seed = $urandom_range(0, 255);
    start_run(10, 0, 0, seed, b0, cs);
    repeat ($urandom_range(6, 20)) tick();
    stop_i = 1'b1;
    s_cyc = cyc + 1;
    tick();
    stop_i = 1'b0;
    wait_done(200, ok);
    err_inject_i = 1'b0;
    started = 0;
    for (int i = b0; i < beats.size(); i++)
      if ((i - b0) % 3 == 0 && beats[i].c <= s_cyc) started++;
    nb = beats.size() - b0;
    n_checks++; if (!ok) $display("FAIL stop_done: got timeout want done"); else n_pass++;
    n_checks++; if (nb != 3 * started || started == 0)
      $display("FAIL stop_frames: got %0d beats want %0d", nb, 3 * started); else n_pass++;
    n_checks++; if (payload_errs(b0, 10, seed, started, 1'b1) != 0)
      $display("FAIL stop_user_payload: got %0d bad want 0", payload_errs(b0, 10, seed, started, 1'b1)); else n_pass++;
    n_checks++; if (sent_cnt_o !== 32'(started) || ok_cnt_o !== 32'(started))
      $display("FAIL stop_counts: got %0d/%0d want %0d", sent_cnt_o, ok_cnt_o, started); else n_pass++;
  endtask

  task automatic test_len0_spurious();
    int b0, cs, seed;
    bit ok;
    auto_en = 1'b1; auto_ok_only = 1'b1; tx_ready_i = 1'b1;
    seed = $urandom_range(0, 255);
    start_run(0, 1, 0, seed, b0, cs);
    wait_done(100, ok);
    n_checks++; if (!ok) $display("FAIL len0_done: got timeout want done"); else n_pass++;
    n_checks++; if (payload_errs(b0, 0, seed, 1, 1'b0) != 0)
      $display("FAIL len0_beat: got %0d bad want 0", payload_errs(b0, 0, seed, 1, 1'b0)); else n_pass++;
    n_checks++; if (spurious_o !== 1'b0) $display("FAIL spur_pre: got %b want 0", spurious_o); else n_pass++;
    tick(); man_status = 1'b1; man_req++;
    repeat (4) @(negedge clk_i);
    n_checks++; if (spurious_o !== 1'b1) $display("FAIL spur_flag: got %b want 1", spurious_o); else n_pass++;
    n_checks++; if (ok_cnt_o !== 32'd1 || err_cnt_o !== 32'd0)
      $display("FAIL spur_counts: got %0d/%0d want 1/0", ok_cnt_o, err_cnt_o); else n_pass++;
  endtask

  task automatic test_midreset();
    int b0, cs;
    auto_en = 1'b1; tx_ready_i = 1'b1;
    start_run(40, 2, 0, 8'h5a, b0, cs);
    repeat (3) tick();
    n_checks++; if (tx_valid_o !== 1'b1) $display("FAIL mrst_pre_valid: got %b want 1", tx_valid_o); else n_pass++;
    rst_n_i = 1'b0;
    #1;
    n_checks++; if (tx_valid_o !== 1'b0 || tx_vldb_o !== 2'd0 || tx_data_o !== 32'd0)
      $display("FAIL mrst_async: got %b/%0d/%h want 0/0/0", tx_valid_o, tx_vldb_o, tx_data_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || sent_cnt_o !== 32'd0)
      $display("FAIL mrst_state: got busy %b sent %0d want 0 0", busy_o, sent_cnt_o); else n_pass++;
    repeat (2) tick();
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL mrst_idle: got %b%b%b want 000", tx_valid_o, busy_o, done_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_shape();
    test_throughput(0);
    test_throughput(2);
    for (int i = 0; i < 3; i++) test_backpressure(i);
    test_credit();
    test_stop_errinj();
    test_len0_spurious();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
